// File: rtl/dac_spi_writer.sv
// Serial DAC writer: accepts offset-binary codes over valid/ready, prepends a
// command field and shifts the frame out MSB-first in SPI mode 0.
module dac_spi_writer #(
  parameter int unsigned        DATA_WIDTH = 12,
  parameter int unsigned        CMD_BITS   = 4,
  parameter logic [CMD_BITS-1:0] CMD       = CMD_BITS'(4'b0011),
  parameter int unsigned        CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  cs_n,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned FRAME = CMD_BITS + DATA_WIDTH;
  localparam int unsigned PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = $clog2(FRAME);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, TAIL, HOLD} state_e;

  state_e             state_q, state_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  // Holds the bits still to be sent after the one currently on mosi.
  logic [FRAME-2:0]   shreg_q, shreg_d;
  logic               cs_n_q, cs_n_d;
  logic               sclk_q, sclk_d;
  logic               mosi_q, mosi_d;
  logic               s_ready_q, s_ready_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic [FRAME-1:0]   frame_in;
  logic               phase_end;

  assign frame_in  = {CMD, s_data};
  assign phase_end = (phase_q == PH_LAST);

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    cs_n_d       = cs_n_q;
    sclk_d       = sclk_q;
    mosi_d       = mosi_q;
    s_ready_d    = s_ready_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        cs_n_d    = 1'b1;
        sclk_d    = 1'b0;
        mosi_d    = 1'b0;
        busy_d    = 1'b0;
        s_ready_d = 1'b1;
        phase_d   = '0;
        bit_d     = '0;
        if (s_valid && s_ready_q) begin
          state_d   = SHIFT;
          shreg_d   = frame_in[FRAME-2:0];
          mosi_d    = frame_in[FRAME-1];
          cs_n_d    = 1'b0;
          s_ready_d = 1'b0;
          busy_d    = 1'b1;
        end
      end

      SHIFT: begin
        if (phase_end) begin
          phase_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q == BIT_LAST) begin
              state_d = TAIL;
            end else begin
              bit_d   = bit_q + BIT_W'(1);
              mosi_d  = shreg_q[FRAME-2];
              shreg_d = {shreg_q[FRAME-3:0], 1'b0};
            end
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      TAIL: begin
        if (phase_end) begin
          phase_d      = '0;
          state_d      = HOLD;
          cs_n_d       = 1'b1;
          mosi_d       = 1'b0;
          frame_done_d = 1'b1;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      HOLD: begin
        if (phase_end) begin
          phase_d   = '0;
          state_d   = IDLE;
          busy_d    = 1'b0;
          s_ready_d = 1'b1;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      bit_q        <= '0;
      shreg_q      <= '0;
      cs_n_q       <= 1'b1;
      sclk_q       <= 1'b0;
      mosi_q       <= 1'b0;
      s_ready_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      cs_n_q       <= cs_n_d;
      sclk_q       <= sclk_d;
      mosi_q       <= mosi_d;
      s_ready_q    <= s_ready_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign cs_n       = cs_n_q;
  assign sclk       = sclk_q;
  assign mosi       = mosi_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
